// File: rtl/fpq_pkg.sv
// Shared types and constants for the pulse value meter.
// The display stage reuses VALUE_W for its bar-graph input.
package fpq_pkg;

  localparam int VALUE_W = 8;
  localparam logic [VALUE_W-1:0] VALUE_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    LATCH
  } state_t;

  function automatic logic [VALUE_W-1:0] sat_inc(
    input logic [VALUE_W-1:0] v
  );
    return (v == VALUE_MAX) ? v : v + VALUE_W'(1);
  endfunction

endpackage

// File: rtl/fpq_sync_edge.sv
// Multi-flop synchronizer for an async input, followed by a
// registered rising-edge detector.
module fpq_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[STAGES-2:0], sig_in};
      prev_q     <= sync_q[STAGES-1];
      edge_pulse <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/fpq_value_meter.sv
// Gated edge counter: counts sig_in rises per window, saturates
// at VALUE_MAX, latches the result and tracks a clearable peak.
module fpq_value_meter
  import fpq_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig_in,
  input  logic               enable,
  input  logic               peak_clr,
  output logic [VALUE_W-1:0] cur_value,
  output logic               value_valid,
  output logic               overflow,
  output logic [VALUE_W-1:0] peak_value,
  output logic               busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t             state;
  logic [GW-1:0]      gate_cnt;
  logic [VALUE_W-1:0] edge_cnt;
  logic               ovf_pend;
  logic               edge_pulse;

  fpq_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .edge_pulse(edge_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf_pend    <= 1'b0;
      cur_value   <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
      peak_value  <= '0;
      busy        <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (peak_clr) peak_value <= '0;
      unique case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf_pend <= 1'b0;
          if (enable) begin
            state <= GATE;
            busy  <= 1'b1;
          end
        end
        GATE: begin
          if (!enable) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_pend <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            if (edge_pulse) begin
              if (edge_cnt == VALUE_MAX) ovf_pend <= 1'b1;
              edge_cnt <= sat_inc(edge_cnt);
            end
            if (gate_cnt == GATE_LAST) state <= LATCH;
          end
        end
        LATCH: begin
          cur_value   <= edge_cnt;
          overflow    <= ovf_pend;
          value_valid <= 1'b1;
          // a coincident clear still loads the fresh result
          if (peak_clr || edge_cnt > peak_value)
            peak_value <= edge_cnt;
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf_pend <= 1'b0;
          if (enable) begin
            state <= GATE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpq_value_meter.sv
// Bench for fpq_value_meter: two instances (short and long gate)
// checked every cycle against a window-level reference model.
module tb_fpq_value_meter;

  localparam int GA = 64;
  localparam int GB = 1200;
  localparam int HMAX = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[2];
  logic sig[2];
  logic en[2];
  logic clr[2];

  logic [7:0] cur_a, cur_b, peak_a, peak_b;
  logic vv_a, vv_b, ovf_a, ovf_b, busy_a, busy_b;

  fpq_value_meter #(.GATE_CYCLES(GA), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst[0]), .sig_in(sig[0]), .enable(en[0]),
    .peak_clr(clr[0]), .cur_value(cur_a), .value_valid(vv_a),
    .overflow(ovf_a), .peak_value(peak_a), .busy(busy_a)
  );

  fpq_value_meter #(.GATE_CYCLES(GB), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst(rst[1]), .sig_in(sig[1]), .enable(en[1]),
    .peak_clr(clr[1]), .cur_value(cur_b), .value_valid(vv_b),
    .overflow(ovf_b), .peak_value(peak_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // reference model: sampled input history plus window bookkeeping
  int   cyc = 0;
  logic hist[2][0:HMAX-1];
  int   gcs[2] = '{GA, GB};
  int   ws[2];
  bit   act[2];
  logic [7:0] m_cur[2], m_peak[2];
  bit   m_ovf[2], m_vv[2], m_busy[2];
  bit   mon_on = 0;

  function automatic int count_rises(int d, int lo, int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++)
      if (n >= 4 && hist[d][n-3] === 1'b1 && hist[d][n-4] === 1'b0)
        c++;
    return c;
  endfunction

  task automatic model_edge(input int d);
    int n = cyc;
    int g = gcs[d];
    int c;
    bit latch;
    if (n < HMAX) hist[d][n] = rst[d] ? 1'b0 : sig[d];
    m_vv[d] = 0;
    if (rst[d]) begin
      act[d] = 0; m_cur[d] = 0; m_peak[d] = 0; m_ovf[d] = 0;
    end else begin
      latch = act[d] && (n == ws[d] + g + 1);
      if (!latch && clr[d]) m_peak[d] = 0;
      if (latch) begin
        c = count_rises(d, ws[d] + 1, ws[d] + g);
        m_cur[d] = (c > 255) ? 8'd255 : 8'(c);
        m_ovf[d] = (c > 255);
        m_vv[d] = 1;
        if (clr[d] || m_cur[d] > m_peak[d]) m_peak[d] = m_cur[d];
        if (en[d]) ws[d] = n;
        else act[d] = 0;
      end else if (act[d]) begin
        if (!en[d]) act[d] = 0;
      end else if (en[d]) begin
        act[d] = 1;
        ws[d] = n;
      end
    end
    m_busy[d] = act[d];
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
    cyc++;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("a_cur", cur_a, m_cur[0]);
      chk("a_ovf", ovf_a, m_ovf[0]);
      chk("a_vv", vv_a, m_vv[0]);
      chk("a_peak", peak_a, m_peak[0]);
      chk("a_busy", busy_a, m_busy[0]);
      chk("b_cur", cur_b, m_cur[1]);
      chk("b_ovf", ovf_b, m_ovf[1]);
      chk("b_vv", vv_b, m_vv[1]);
      chk("b_peak", peak_b, m_peak[1]);
      chk("b_busy", busy_b, m_busy[1]);
    end
  end

  // one full window with np pulses (2 high / 2 low) from its start
  task automatic window(input int d, input int np, input bit clr_last);
    int g = gcs[d];
    for (int c = 0; c <= g + 1; c++) begin
      en[d]  = (c <= g);
      sig[d] = (c >= 1 && c < 1 + 4 * np) ? (((c - 1) % 4) < 2) : 1'b0;
      clr[d] = clr_last && (c == g + 1);
      @(negedge clk);
    end
    en[d] = 0; sig[d] = 0; clr[d] = 0;
  endtask

  initial begin
    bit rl_v = 0;
    int rl_n = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; sig[d] = 0; en[d] = 0; clr[d] = 0;
    end
    repeat (3) @(negedge clk);
    mon_on = 1;
    chk("rst_cur", cur_a, 0);
    chk("rst_peak", peak_a, 0);
    chk("rst_busy", busy_a, 0);
    rst[0] = 0; rst[1] = 0;
    repeat (6) @(negedge clk);

    window(0, 5, 0);
    chk("cnt_cur", cur_a, 5);
    chk("cnt_ovf", ovf_a, 0);
    chk("cnt_vv", vv_a, 1);
    @(negedge clk);
    chk("cnt_vv_off", vv_a, 0);

    window(0, 9, 0);
    window(0, 3, 0);
    chk("pk_cur", cur_a, 3);
    chk("pk_peak", peak_a, 9);
    window(0, 4, 1);
    chk("pk_clr", peak_a, 4);

    // abort with gate_cnt at 8
    for (int c = 0; c <= 9; c++) begin
      en[0] = (c < 9);
      sig[0] = (c >= 1 && ((c - 1) % 4) < 2);
      @(negedge clk);
    end
    sig[0] = 0;
    chk("ab_busy", busy_a, 0);
    chk("ab_vv", vv_a, 0);
    chk("ab_cur", cur_a, 4);
    repeat (4) @(negedge clk);

    // reset mid-window after 6 edges
    for (int c = 0; c <= 30; c++) begin
      en[0] = 1;
      sig[0] = (c >= 1 && c < 25) ? (((c - 1) % 4) < 2) : 1'b0;
      rst[0] = (c == 30);
      @(negedge clk);
    end
    rst[0] = 0; en[0] = 0;
    chk("rm_cur", cur_a, 0);
    chk("rm_peak", peak_a, 0);
    chk("rm_busy", busy_a, 0);
    repeat (4) @(negedge clk);
    window(0, 2, 0);
    chk("rm_win", cur_a, 2);

    // late pulse lands in the LATCH cycle and is lost
    for (int c = 0; c <= 2 * GA + 2; c++) begin
      en[0] = (c <= 2 * GA + 1);
      sig[0] = (c == 1 || c == 2 || c == GA - 2 || c == GA - 1);
      @(negedge clk);
      if (c == GA + 1) begin
        chk("dt_w1", cur_a, 1);
        chk("dt_vv1", vv_a, 1);
      end
    end
    en[0] = 0; sig[0] = 0;
    chk("dt_w2", cur_a, 0);
    repeat (4) @(negedge clk);

    window(1, 300, 0);
    chk("sat_cur", cur_b, 255);
    chk("sat_ovf", ovf_b, 1);
    window(1, 10, 0);
    chk("sat2_cur", cur_b, 10);
    chk("sat2_ovf", ovf_b, 0);

    // random run-length input, rare aborts, clears and resets
    for (int i = 0; i < 4000; i++) begin
      if (rl_n == 0) begin
        rl_v = ~rl_v;
        rl_n = $urandom_range(2, 5);
      end
      rl_n--;
      sig[0] = rl_v;
      en[0]  = ($urandom_range(0, 299) != 0);
      clr[0] = ($urandom_range(0, 59) == 0);
      rst[0] = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    en[0] = 0; clr[0] = 0; rst[0] = 0; sig[0] = 0;
    repeat (4) @(negedge clk);
    mon_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
